regwb_queue: RTL and testbench

REGWB_QUEUE -- requirements
Module: regwb_queue

---
 rtl/regwb_queue.sv | 138 +++++++++++++
 tb/tb_regwb_queue.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwb_queue.sv
//------------------------------------------------------------------------------
// regwb_queue
//   Register write-back queue. Buffers pending register-file writes in a
//   DEPTH-entry FIFO and drains one entry per unstalled cycle into a
//   registered write-port stage (RegWrite / WriteRegister / WriteData).
//   Writes to register 0 complete the handshake but are dropped.
//
//   Optional feature (macro REGWB_BYPASS_EN): two combinational lookup ports
//   report whether a write to a given register is still pending (write-port
//   stage or queue) and return the youngest pending data.
//
// Ports
//   Clk            clock, all state updates on rising edge
//   Reset          asynchronous active-high reset
//   InValid        producer offers a write this cycle
//   InReady        queue can accept (Count < DEPTH)
//   InReg/InData   destination register / data of offered write
//   Stall          suppresses draining this cycle
//   RegWrite       register-file write enable (one cycle per drained entry)
//   WriteRegister  register-file write address
//   WriteData      register-file write data
//   Count          entries queued, write-port stage excluded
//   LookupReg1/2   bypass read addresses            (REGWB_BYPASS_EN)
//   Hit1/2         pending write exists for address (REGWB_BYPASS_EN)
//   HitData1/2     youngest pending data            (REGWB_BYPASS_EN)
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regwb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  InReg,
  input  logic [31:0] InData,
  input  logic        Stall,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic [4:0]  Count
`ifdef REGWB_BYPASS_EN
  ,
  input  logic [4:0]  LookupReg1,
  input  logic [4:0]  LookupReg2,
  output logic        Hit1,
  output logic        Hit2,
  output logic [31:0] HitData1,
  output logic [31:0] HitData2
`endif
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [4:0]    reg_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count_q;

  logic accept;
  logic push;
  logic pop;

  // Ready depends only on occupancy, never on a same-cycle drain.
  assign InReady = (count_q < DEPTH_C);
  assign accept  = InValid & InReady;
  // Register 0 is hard-wired: accept the request but never store it.
  assign push    = accept & (InReg != 5'd0);
  // Pop uses pre-edge occupancy, so an entry pushed into an empty queue
  // cannot fall through on the same edge.
  assign pop     = (count_q != 5'd0) & ~Stall;
  assign Count   = count_q;

  // Entry storage needs no reset: validity is tracked by the pointers/count.
  always_ff @(posedge Clk) begin
    if (push) begin
      reg_mem[wr_ptr]  <= InReg;
      data_mem[wr_ptr] <= InData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      RegWrite <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + AW'(1);
        WriteRegister <= reg_mem[rd_ptr];
        WriteData     <= data_mem[rd_ptr];
      end
      count_q <= count_q + {4'd0, push} - {4'd0, pop};
    end
  end

`ifdef REGWB_BYPASS_EN
  // Search oldest to youngest so the last match (youngest) wins: the
  // write-port stage is older than anything still in the queue.
  function automatic logic [32:0] search(input logic [4:0] addr);
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = '0;
    if (addr != 5'd0) begin
      if (RegWrite && (WriteRegister == addr)) begin
        res = {1'b1, WriteData};
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + AW'(i);
        if ((5'(i) < count_q) && (reg_mem[idx] == addr)) begin
          res = {1'b1, data_mem[idx]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    {Hit1, HitData1} = search(LookupReg1);
    {Hit2, HitData2} = search(LookupReg2);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regwb_queue.sv
//------------------------------------------------------------------------------
// tb_regwb_queue
//   Directed self-checking bench for regwb_queue. A queue-based reference
//   model tracks pending writes; every falling edge the outputs are compared
//   with it, and literal expectations pin the key scenarios.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regwb_queue;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InReg;
  logic [31:0] InData;
  logic        Stall;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  Count;
`ifdef REGWB_BYPASS_EN
  logic [4:0]  LookupReg1;
  logic [4:0]  LookupReg2;
  logic        Hit1;
  logic        Hit2;
  logic [31:0] HitData1;
  logic [31:0] HitData2;
`endif

  regwb_queue #(.DEPTH(DEPTH)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .InValid       (InValid),
    .InReady       (InReady),
    .InReg         (InReg),
    .InData        (InData),
    .Stall         (Stall),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .Count         (Count)
`ifdef REGWB_BYPASS_EN
    ,
    .LookupReg1    (LookupReg1),
    .LookupReg2    (LookupReg2),
    .Hit1          (Hit1),
    .Hit2          (Hit2),
    .HitData1      (HitData1),
    .HitData2      (HitData2)
`endif
  );

  always #5 Clk = ~Clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_rw = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_wd = '0;
  bit          m_pop;
  bit          m_acc;
  ent_t        m_e;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q.delete();
      m_rw = 1'b0;
      m_wr = '0;
      m_wd = '0;
    end else begin
      m_pop = (q.size() > 0) && !Stall;
      m_acc = InValid && (q.size() < DEPTH);
      m_rw  = m_pop;
      if (m_pop) begin
        m_e  = q.pop_front();
        m_wr = m_e.r;
        m_wd = m_e.d;
      end
      if (m_acc && InReg != 5'd0) q.push_back('{InReg, InData});
    end
  end

  // Youngest pending data for an address, or miss.
  function automatic logic [32:0] model_lookup(input logic [4:0] a);
    logic [32:0] res;
    res = '0;
    if (a != 5'd0) begin
      if (m_rw && m_wr == a) res = {1'b1, m_wd};
      foreach (q[i]) if (q[i].r == a) res = {1'b1, q[i].d};
    end
    return res;
  endfunction

  bit cmp_en = 1'b0;

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("count",   32'(Count),         32'(q.size()));
      check("inready", 32'(InReady),       32'(q.size() < DEPTH));
      check("regwrite",32'(RegWrite),      32'(m_rw));
      check("wreg",    32'(WriteRegister), 32'(m_wr));
      check("wdata",   WriteData,          m_wd);
`ifdef REGWB_BYPASS_EN
      check("hit1",    32'(Hit1),     32'(model_lookup(LookupReg1) >> 32));
      check("hitdata1",HitData1,      model_lookup(LookupReg1)[31:0]);
      check("hit2",    32'(Hit2),     32'(model_lookup(LookupReg2) >> 32));
      check("hitdata2",HitData2,      model_lookup(LookupReg2)[31:0]);
`endif
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] r, input logic [31:0] d);
    InValid = 1'b1;
    InReg   = r;
    InData  = d;
  endtask

  initial begin
    Reset   = 1'b1;
    InValid = 1'b0;
    InReg   = '0;
    InData  = '0;
    Stall   = 1'b0;
`ifdef REGWB_BYPASS_EN
    LookupReg1 = 5'd0;
    LookupReg2 = 5'd0;
`endif
    cmp_en  = 1'b1;
    tick();
    tick();
    // Reset state
    check("rst_count",    32'(Count),    32'd0);
    check("rst_inready",  32'(InReady),  32'd1);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_wdata",    WriteData,     32'd0);
    Reset = 1'b0;

    // Single write, two-edge latency, one-cycle pulse
    offer(5'd5, 32'hDEADBEEF);
    tick();
    InValid = 1'b0;
    check("lat_count1", 32'(Count),    32'd1);
    check("lat_rw0",    32'(RegWrite), 32'd0);
    tick();
    check("lat_rw1",    32'(RegWrite),      32'd1);
    check("lat_wreg",   32'(WriteRegister), 32'd5);
    check("lat_wdata",  WriteData,          32'hDEADBEEF);
    tick();
    check("lat_rw_off", 32'(RegWrite), 32'd0);
    check("lat_hold",   WriteData,     32'hDEADBEEF);

    // Register 0 write is swallowed
    offer(5'd0, 32'h12345678);
    check("r0_ready", 32'(InReady), 32'd1);
    tick();
    InValid = 1'b0;
    check("r0_count", 32'(Count), 32'd0);
    tick();
    check("r0_rw", 32'(RegWrite), 32'd0);

    // Fill under stall, fifth offer refused, drain in order
    Stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      offer(5'(i), 32'h100 + 32'(i));
      if (i == 5) check("full_ready", 32'(InReady), 32'd0);
      tick();
    end
    InValid = 1'b0;
    check("full_count", 32'(Count), 32'd4);
    tick();
    tick();
    check("stall_hold", 32'(Count), 32'd4);
    Stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("order_rw",   32'(RegWrite),      32'd1);
      check("order_reg",  32'(WriteRegister), 32'(k));
      check("order_data", WriteData,          32'h100 + 32'(k));
    end
    tick();
    check("drained_rw", 32'(RegWrite), 32'd0);
    check("drained_cnt",32'(Count),    32'd0);

`ifdef REGWB_BYPASS_EN
    // Youngest of two pending writes to one register wins; reg 0 never hits
    Stall = 1'b1;
    offer(5'd7, 32'h1);
    tick();
    offer(5'd7, 32'h2);
    tick();
    InValid    = 1'b0;
    LookupReg1 = 5'd7;
    LookupReg2 = 5'd0;
    #1;
    check("byp_hit1",  32'(Hit1), 32'd1);
    check("byp_data1", HitData1,  32'h2);
    check("byp_hit2",  32'(Hit2), 32'd0);
    check("byp_data2", HitData2,  32'h0);
    Stall = 1'b0;
    tick();
    check("byp_stage_young", HitData1, 32'h2);
    tick();
    check("byp_stage_hit", 32'(Hit1), 32'd1);
    tick();
    check("byp_gone", 32'(Hit1), 32'd0);
`endif

    // Full queue, continuous offers: one write per cycle sustained
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(5'(10 + i), 32'hA0 + 32'(i));
      tick();
    end
    Stall = 1'b0;
    for (int j = 0; j < 10; j++) begin
      offer(5'(14 + j), 32'hB0 + 32'(j));
      tick();
      check("thr_rw", 32'(RegWrite), 32'd1);
      if (j == 0) begin
        check("thr_first_reg", 32'(WriteRegister), 32'd10);
        check("thr_ready",     32'(InReady),       32'd1);
        check("thr_count",     32'(Count),         32'd3);
      end
    end
    InValid = 1'b0;
    for (int j = 0; j < 5; j++) tick();

    // Asynchronous reset mid-operation
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(5'(20 + i), 32'hC0 + 32'(i));
      tick();
    end
    InValid = 1'b0;
    Stall   = 1'b0;
    tick();
    check("pre_rst_count", 32'(Count),    32'd3);
    check("pre_rst_rw",    32'(RegWrite), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("arst_rw",    32'(RegWrite), 32'd0);
    check("arst_count", 32'(Count),    32'd0);
    check("arst_ready", 32'(InReady),  32'd1);
    tick();
    tick();
    Reset = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      check("post_rst_rw", 32'(RegWrite), 32'd0);
    end

    // Mixed pattern: repeated addresses, reg 0, stall toggling
    for (int i = 0; i < 40; i++) begin
      InValid = (i % 4) != 3;
      InReg   = 5'(i % 4);
      InData  = 32'(i) * 32'h01010101;
      Stall   = ((i % 5) == 2) || ((i % 7) == 0);
`ifdef REGWB_BYPASS_EN
      LookupReg1 = 5'(i % 4);
      LookupReg2 = 5'((i + 1) % 4);
`endif
      tick();
    end
    InValid = 1'b0;
    Stall   = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    check("end_count", 32'(Count), 32'd0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
